// File: rtl/norm_forward.sv
// Forward normalisation stage: serial mean/variance, iterative square root,
// reciprocal std and per-element affine output, with an idle/busy/done handshake.
module norm_forward #(
  parameter int unsigned IL    = 4,
  parameter int unsigned FL    = 16,
  parameter int unsigned size  = 16,
  parameter int unsigned width = $clog2(size)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [size-1:0][IL+FL-1:0]     batch,
  input  logic [3:0]                     num,
  input  logic [IL+FL-1:0]               gamma,
  input  logic [IL+FL-1:0]               beta,
  input  logic                           input_ready,
  input  logic                           output_taken,
  output logic [size-1:0][IL+FL-1:0]     norm,
  output logic [size-1:0][IL+FL-1:0]     out,
  output logic [IL+FL-1:0]               mu,
  output logic [IL+FL-1:0]               vari,
  output logic [1:0]                     state,
  output logic                           done
);

  localparam int unsigned W  = IL + FL;
  localparam int unsigned AW = W + width;
  localparam int unsigned RW = W + 4;
  localparam int unsigned NW = width + 1;
  localparam int unsigned CW = $clog2((W > size) ? W : size) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    P_SUM  = 3'd0,
    P_MEAN = 3'd1,
    P_VAR  = 3'd2,
    P_ROOT = 3'd3,
    P_INV  = 3'd4,
    P_NORM = 3'd5
  } phase_e;

  state_e                    state_q, state_d;
  phase_e                    phase_q, phase_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NW-1:0]             num_q, num_d;
  logic [size-1:0][W-1:0]    batch_q, batch_d;
  logic [W-1:0]              gamma_q, gamma_d;
  logic [W-1:0]              beta_q, beta_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic [W-1:0]              mu_q, mu_d;
  logic [W-1:0]              vari_q, vari_d;
  logic [2*W-1:0]            rad_q, rad_d;
  logic [RW-1:0]             rem_q, rem_d;
  logic [W-1:0]              root_q, root_d;
  logic [2*W-1:0]            inv_q, inv_d;
  logic [size-1:0][W-1:0]    norm_q, norm_d;
  logic [size-1:0][W-1:0]    out_q, out_d;
  logic                      done_q, done_d;

  logic [width-1:0]          idx_c;
  logic signed [W-1:0]       x_c;
  logic signed [W:0]         diff_c;
  logic signed [2*W+1:0]     sq_c;
  logic signed [AW-1:0]      acc_var_c;
  logic signed [AW-1:0]      num_s_c;
  logic [W-1:0]              vari_new_c;
  logic                      last_c;
  logic [RW+1:0]             rem_sh_c;
  logic [RW+1:0]             trial_c;
  logic signed [3*W+1:0]     prod_c;
  logic signed [W-1:0]       nrm_c;
  logic signed [2*W-1:0]     gmul_c;
  logic [W-1:0]              oval_c;

  // Shared datapath: current element, deviation, square, sqrt trial and affine terms
  always_comb begin
    idx_c      = cnt_q[width-1:0];
    x_c        = $signed(batch_q[idx_c]);
    diff_c     = (W+1)'(x_c) - (W+1)'($signed(mu_q));
    sq_c       = (2*W+2)'(diff_c) * (2*W+2)'(diff_c);
    acc_var_c  = acc_q + AW'(sq_c >>> FL);
    num_s_c    = $signed(AW'(num_q));
    vari_new_c = W'(acc_var_c / num_s_c);
    last_c     = (cnt_q + CW'(1)) == CW'(num_q);
    rem_sh_c   = {rem_q, rad_q[2*W-1 -: 2]};
    trial_c    = (RW+2)'({root_q, 2'b01});
    prod_c     = (3*W+2)'(diff_c) * (3*W+2)'($signed({1'b0, inv_q}));
    nrm_c      = W'(prod_c >>> FL);
    gmul_c     = (2*W)'($signed(gamma_q)) * (2*W)'(nrm_c);
    oval_c     = W'(gmul_c >>> FL) + beta_q;
  end

  // Next-state and phase sequencing
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    batch_d = batch_q;
    gamma_d = gamma_q;
    beta_d  = beta_q;
    acc_d   = acc_q;
    mu_d    = mu_q;
    vari_d  = vari_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    inv_d   = inv_q;
    norm_d  = norm_q;
    out_d   = out_q;

    unique case (state_q)
      S_IDLE: begin
        if (input_ready) begin
          batch_d = batch;
          num_d   = (NW'(num) > NW'(size)) ? NW'(size) : NW'(num);
          gamma_d = gamma;
          beta_d  = beta;
          acc_d   = '0;
          cnt_d   = '0;
          phase_d = P_SUM;
          mu_d    = '0;
          vari_d  = '0;
          rad_d   = '0;
          rem_d   = '0;
          root_d  = '0;
          inv_d   = '0;
          norm_d  = '0;
          out_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (num_q == '0) begin
          state_d = S_DONE;
        end else begin
          unique case (phase_q)
            P_SUM: begin
              acc_d = acc_q + AW'(x_c);
              if (last_c) begin
                cnt_d   = '0;
                phase_d = P_MEAN;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            P_MEAN: begin
              mu_d    = W'(acc_q / num_s_c);
              acc_d   = '0;
              phase_d = P_VAR;
            end
            P_VAR: begin
              acc_d = acc_var_c;
              if (last_c) begin
                vari_d  = vari_new_c;
                // epsilon of one LSB keeps the root strictly positive
                rad_d   = ((2*W)'({1'b0, vari_new_c}) + (2*W)'(1)) << FL;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                phase_d = P_ROOT;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            P_ROOT: begin
              rad_d = rad_q << 2;
              if (rem_sh_c >= trial_c) begin
                rem_d  = RW'(rem_sh_c - trial_c);
                root_d = W'({root_q, 1'b1});
              end else begin
                rem_d  = RW'(rem_sh_c);
                root_d = W'({root_q, 1'b0});
              end
              if (cnt_q == CW'(W - 1)) begin
                cnt_d   = '0;
                phase_d = P_INV;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            P_INV: begin
              inv_d   = ((2*W)'(1) << (2*FL)) / (2*W)'(root_q);
              cnt_d   = '0;
              phase_d = P_NORM;
            end
            P_NORM: begin
              norm_d[idx_c] = nrm_c;
              out_d[idx_c]  = oval_c;
              if (last_c) begin
                cnt_d   = '0;
                state_d = S_DONE;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            default: phase_d = P_SUM;
          endcase
        end
      end
      S_DONE: begin
        if (output_taken) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= P_SUM;
      cnt_q   <= '0;
      num_q   <= '0;
      batch_q <= '0;
      gamma_q <= '0;
      beta_q  <= '0;
      acc_q   <= '0;
      mu_q    <= '0;
      vari_q  <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      inv_q   <= '0;
      norm_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      batch_q <= batch_d;
      gamma_q <= gamma_d;
      beta_q  <= beta_d;
      acc_q   <= acc_d;
      mu_q    <= mu_d;
      vari_q  <= vari_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      inv_q   <= inv_d;
      norm_q  <= norm_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign norm  = norm_q;
  assign out   = out_q;
  assign mu    = mu_q;
  assign vari  = vari_q;
  assign state = state_q;
  assign done  = done_q;

endmodule
